traffic_light: RTL and testbench

//   Single-road traffic-light controller with a pedestrian request input.

---
 rtl/traffic_light.sv | 104 ++++++++++
 tb/tb_traffic_light.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light.sv
// Single-road traffic light with latched pedestrian request.
// RED -> GREEN -> YELLOW -> RED. A request ends green early and stretches the next red.
module traffic_light #(
  parameter int unsigned GREEN_CYCLES   = 20,
  parameter int unsigned MIN_GREEN      = 5,
  parameter int unsigned YELLOW_CYCLES  = 5,
  parameter int unsigned RED_CYCLES     = 15,
  parameter int unsigned PED_RED_CYCLES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pdst,
  output logic [2:0] light
);

  localparam int unsigned MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int unsigned MAX_RED = (PED_RED_CYCLES > RED_CYCLES) ? PED_RED_CYCLES : RED_CYCLES;
  localparam int unsigned MAX_DUR = (MAX_GY > MAX_RED) ? MAX_GY : MAX_RED;
  localparam int unsigned CW      = $clog2(MAX_DUR) + 1;

  // Counter holds (cycles elapsed - 1); a phase ends on the edge where it equals duration-1.
  localparam logic [CW-1:0] RED_LAST     = CW'(RED_CYCLES - 1);
  localparam logic [CW-1:0] PED_RED_LAST = CW'(PED_RED_CYCLES - 1);
  localparam logic [CW-1:0] GREEN_LAST   = CW'(GREEN_CYCLES - 1);
  localparam logic [CW-1:0] MIN_LAST     = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST  = CW'(YELLOW_CYCLES - 1);

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ped_latch;
  logic          ped_serve;
  logic [CW-1:0] red_last_c;

  always_comb begin
    red_last_c = ped_serve ? PED_RED_LAST : RED_LAST;
  end

  // Phase sequencing, request latch and registered lamp decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RED;
      cnt       <= '0;
      ped_latch <= 1'b0;
      ped_serve <= 1'b0;
      light     <= L_RED;
    end else begin
      case (state)
        S_RED: begin
          // Requests during a crossing red are dropped.
          if (pdst && !ped_serve) ped_latch <= 1'b1;
          if (cnt == red_last_c) begin
            state     <= S_GREEN;
            light     <= L_GREEN;
            cnt       <= '0;
            ped_serve <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GREEN: begin
          if (pdst) ped_latch <= 1'b1;
          if ((cnt == GREEN_LAST) || (ped_latch && (cnt >= MIN_LAST))) begin
            state <= S_YELLOW;
            light <= L_YELLOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_YELLOW: begin
          if (cnt == YELLOW_LAST) begin
            // A request arriving on this edge joins the crossing being granted.
            state     <= S_RED;
            light     <= L_RED;
            cnt       <= '0;
            ped_serve <= ped_latch | pdst;
            ped_latch <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
            if (pdst) ped_latch <= 1'b1;
          end
        end
        default: begin
          state     <= S_RED;
          light     <= L_RED;
          cnt       <= '0;
          ped_latch <= 1'b0;
          ped_serve <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: phase-level reference model, directed pedestrian cases, random requests.
module tb_traffic_light;

  localparam int G_DUR  = 20;
  localparam int MIN_G  = 5;
  localparam int Y_DUR  = 5;
  localparam int R_DUR  = 15;
  localparam int PR_DUR = 30;

  localparam int PH_RED = 0;
  localparam int PH_GRN = 1;
  localparam int PH_YEL = 2;

  logic       clk;
  logic       rst;
  logic       pdst;
  logic [2:0] light;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: phase, cycles completed in phase, pending request, crossing-red flag
  int m_ph;
  int m_el;
  bit m_req;
  bit m_cross;

  // observed run lengths of each lamp
  logic [2:0] cur_lamp;
  int run_len;
  int last_red, last_grn, last_yel;

  traffic_light #(
    .GREEN_CYCLES(G_DUR), .MIN_GREEN(MIN_G), .YELLOW_CYCLES(Y_DUR),
    .RED_CYCLES(R_DUR), .PED_RED_CYCLES(PR_DUR)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pdst (pdst),
    .light(light)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] lamp_of(input int ph);
    case (ph)
      PH_GRN:  return 3'b001;
      PH_YEL:  return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Model advances once per rising edge from the rules of each phase.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = PH_RED; m_el = 0; m_req = 1'b0; m_cross = 1'b0;
    end else begin
      bit take;
      bit req_before;
      take = pdst && !(m_ph == PH_RED && m_cross);
      req_before = m_req;
      m_el = m_el + 1;
      case (m_ph)
        PH_RED: begin
          if (m_el == (m_cross ? PR_DUR : R_DUR)) begin
            m_ph = PH_GRN; m_el = 0; m_cross = 1'b0;
          end
          m_req = m_req | take;
        end
        PH_GRN: begin
          if (m_el == G_DUR || (req_before && m_el >= MIN_G)) begin
            m_ph = PH_YEL; m_el = 0;
          end
          m_req = m_req | take;
        end
        default: begin
          if (m_el == Y_DUR) begin
            m_ph = PH_RED; m_el = 0; m_cross = req_before | take; m_req = 1'b0;
          end else begin
            m_req = m_req | take;
          end
        end
      endcase
    end
  end

  // Per-cycle compare against the model plus lamp run-length tracking.
  always @(negedge clk) begin
    if (!rst) begin
      cur_lamp = 3'b100;
      run_len  = 0;
    end else begin
      chk("onehot", $countones(light), 1);
      chk("lamp", int'(light), int'(lamp_of(m_ph)));
      if (light == cur_lamp) begin
        run_len++;
      end else begin
        case (cur_lamp)
          3'b001:  last_grn = run_len;
          3'b010:  last_yel = run_len;
          default: last_red = run_len;
        endcase
        cur_lamp = light;
        run_len  = 1;
      end
    end
  end

  task automatic wait_model(input int ph, input int el);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (m_ph == ph && m_el == el) return;
    end
    chk("wait_timeout", 0, 1);
  endtask

  task automatic pulse();
    pdst = 1'b1;
    @(negedge clk);
    #1;
    pdst = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_rst_lamp", int'(light), 4);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int hold;
    rst = 1'b1; pdst = 1'b0;
    last_red = 0; last_grn = 0; last_yel = 0;
    cur_lamp = 3'b100; run_len = 0;
    #2 rst = 1'b0;
    #1 chk("reset_lamp", int'(light), 4);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // normal cycling
    wait_model(PH_YEL, 0); chk("t1_red", last_red, R_DUR);
    wait_model(PH_RED, 0); chk("t1_green", last_grn, G_DUR);
    wait_model(PH_GRN, 0); chk("t1_yellow", last_yel, Y_DUR); chk("t1_red2", last_red, R_DUR);

    // request at green cycle 10
    wait_model(PH_GRN, 9); pulse();
    wait_model(PH_GRN, 0);
    chk("t2_green", last_grn, 11); chk("t2_yellow", last_yel, Y_DUR); chk("t2_red", last_red, PR_DUR);
    wait_model(PH_YEL, 0); chk("t2_green_after", last_grn, G_DUR);

    // request at green cycle 1
    wait_model(PH_GRN, 0); pulse();
    wait_model(PH_RED, 0); chk("t3_green", last_grn, MIN_G);
    wait_model(PH_GRN, 0); chk("t3_red", last_red, PR_DUR);

    // request during a normal red
    wait_model(PH_RED, 3); pulse();
    wait_model(PH_YEL, 0); chk("t4_red", last_red, R_DUR); chk("t4_green", last_grn, MIN_G);
    wait_model(PH_GRN, 0); chk("t4_red_after", last_red, PR_DUR);

    // request during a crossing red is dropped
    pulse();
    wait_model(PH_RED, 10); pulse();
    wait_model(PH_YEL, 0); chk("t5_red", last_red, PR_DUR); chk("t5_green", last_grn, G_DUR);
    wait_model(PH_GRN, 0); chk("t5_red_after", last_red, R_DUR);

    // async reset mid-green with a request pending
    wait_model(PH_GRN, 2); pulse();
    async_reset();
    wait_model(PH_GRN, 0); chk("t6_red", last_red, R_DUR);
    wait_model(PH_YEL, 0); chk("t6_green", last_grn, G_DUR);

    // random requests: mostly short pulses, occasional long holds, one mid-run reset
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      #1;
      if (hold > 0) begin
        hold--;
        pdst = 1'b1;
      end else begin
        pdst = ($urandom_range(0, 99) < 3);
        if (pdst && $urandom_range(0, 3) == 0) hold = $urandom_range(1, 12);
      end
      if (i == 1200) async_reset();
    end
    pdst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
